// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-port register file with write bypass and busy scoreboard
module reg_file_mp #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*DW-1:0]   pa,
    output logic [NRD-1:0]      busy,
    input  logic [AW-1:0]       rd,
    input  logic [DW-1:0]       pd,
    input  logic                en,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    output logic [15:0]         wcnt
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } sb_state_t;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] sb_busy;
    logic             wr_r0;

    assign wr_r0 = (ZERO_R0 != 0) && (rd == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wcnt <= '0;
        end else if (en) begin
            // A write to the hardwired zero register still counts as committed.
            wcnt <= wcnt + 16'd1;
            if (!wr_r0) begin
                mem[rd] <= pd;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_sb
        if ((ZERO_R0 != 0) && (i == 0)) begin : g_r0
            assign sb_busy[i] = 1'b0;
        end else begin : g_reg
            sb_state_t st_q;
            sb_state_t st_d;
            logic      hit_iss;
            logic      hit_wr;

            assign hit_iss = iss_en && (iss_rd == AW'(i));
            assign hit_wr  = en && (rd == AW'(i));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    st_q <= S_IDLE;
                end else begin
                    st_q <= st_d;
                end
            end

            // An issue on the same edge as the retiring write wins: the new producer is still in flight.
            always_comb begin
                st_d = st_q;
                case (st_q)
                    S_IDLE: begin
                        if (hit_iss) begin
                            st_d = S_PEND;
                        end
                    end
                    S_PEND: begin
                        if (hit_iss) begin
                            st_d = S_PEND;
                        end else if (hit_wr) begin
                            st_d = S_IDLE;
                        end
                    end
                    default: st_d = S_IDLE;
                endcase
            end

            assign sb_busy[i] = (st_q == S_PEND);
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          fwd;

        assign addr    = ra[k*AW +: AW];
        assign is_zero = (ZERO_R0 != 0) && (addr == '0);
        assign fwd     = (BYPASS != 0) && en && (rd == addr) && !is_zero;

        // Reset also masks the bypass path so every port reads zero while rst_n is low.
        assign pa[k*DW +: DW] = (!rst_n || is_zero) ? '0 : (fwd ? pd : mem[addr]);
        assign busy[k]        = rst_n && !is_zero && !fwd && sb_busy[addr];
    end

endmodule
